// File: rtl/ws2812_cmd_pkg.sv
// Shared definitions for the ws2812 command queue: register map, bit fields,
// drain FSM states and the command word layout.
package ws2812_cmd_pkg;

   localparam logic [31:0] OFF_DATA   = 32'h0;
   localparam logic [31:0] OFF_STATUS = 32'h4;
   localparam logic [31:0] OFF_CTRL   = 32'h8;

   localparam int unsigned ST_FULL   = 8;
   localparam int unsigned ST_EMPTY  = 9;
   localparam int unsigned ST_BUSY   = 10;
   localparam int unsigned ST_OVF    = 16;
   localparam int unsigned ST_PAUSED = 17;

   localparam int unsigned CTRL_FLUSH   = 0;
   localparam int unsigned CTRL_CLR_OVF = 1;
   localparam int unsigned CTRL_PAUSE   = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP
   } drain_state_t;

   typedef struct packed {
      logic [7:0]  led_num;
      logic [23:0] rgb;
   } cmd_word_t;

endpackage

// File: rtl/ws2812_cmd_fifo.sv
// DEPTH x 32 synchronous FIFO; pushes when full and pops when empty are dropped,
// flush clears pointers and level in the same cycle.
module ws2812_cmd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [31:0]              din,
   output logic [31:0]              dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push_ok) - LW'(pop_ok);
      end
   end

endmodule

// File: rtl/ws2812_cmd_queue.sv
// Wishbone-fed command queue that drains {led_num, rgb} words to the ws2812
// core as single-cycle write pulses separated by GAP_CYCLES idle cycles.
module ws2812_cmd_queue
   import ws2812_cmd_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h30000300,
   parameter int          DEPTH      = 8,
   parameter int          GAP_CYCLES = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [7:0]  led_num_o,
   output logic [23:0] rgb_o,
   output logic        write_o,
   output logic        busy_o
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);

   drain_state_t  state;
   logic [GW-1:0] gap_cnt;
   logic          overflow;
   logic          pause;
   logic          req_served;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic [31:0]   fifo_dout;
   cmd_word_t     head;
   logic          hit_data, hit_status, hit_ctrl;
   logic          valid, wr, push, pop, flush, ctrl_wr;
   logic [31:0]   status_word;
   logic [31:0]   ctrl_word;

   assign hit_data   = (wbs_adr_i == BASE_ADDR + OFF_DATA);
   assign hit_status = (wbs_adr_i == BASE_ADDR + OFF_STATUS);
   assign hit_ctrl   = (wbs_adr_i == BASE_ADDR + OFF_CTRL);

   // req_served blocks a second ack while the master keeps a served request asserted
   assign valid   = wbs_cyc_i & wbs_stb_i & (hit_data | hit_status | hit_ctrl)
                    & ~wbs_ack_o & ~req_served;
   assign wr      = valid & wbs_we_i;
   assign push    = wr & hit_data & (wbs_sel_i == 4'hF);
   assign ctrl_wr = wr & hit_ctrl & wbs_sel_i[0];
   assign flush   = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
   assign pop     = (state == S_ISSUE);
   assign head    = cmd_word_t'(fifo_dout);
   assign busy_o  = ~empty | (state != S_IDLE);

   ws2812_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (wbs_dat_i),
      .dout  (fifo_dout),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      status_word            = '0;
      status_word[4:0]       = 5'(level);
      status_word[ST_FULL]   = full;
      status_word[ST_EMPTY]  = empty;
      status_word[ST_BUSY]   = busy_o;
      status_word[ST_OVF]    = overflow;
      status_word[ST_PAUSED] = pause;
      ctrl_word              = '0;
      ctrl_word[CTRL_PAUSE]  = pause;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         req_served <= 1'b0;
         overflow   <= 1'b0;
         pause      <= 1'b0;
      end else begin
         wbs_ack_o <= valid;
         wbs_dat_o <= '0;
         if (valid && !wbs_we_i) begin
            if (hit_status)    wbs_dat_o <= status_word;
            else if (hit_ctrl) wbs_dat_o <= ctrl_word;
         end
         if (!(wbs_cyc_i && wbs_stb_i)) req_served <= 1'b0;
         else if (valid)                req_served <= 1'b1;
         if (push && full)                                overflow <= 1'b1;
         else if (ctrl_wr && wbs_dat_i[CTRL_CLR_OVF])     overflow <= 1'b0;
         if (ctrl_wr) pause <= wbs_dat_i[CTRL_PAUSE];
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state     <= S_IDLE;
         gap_cnt   <= '0;
         write_o   <= 1'b0;
         led_num_o <= '0;
         rgb_o     <= '0;
      end else begin
         write_o <= 1'b0;
         case (state)
            S_IDLE: if (!empty && !pause) state <= S_ISSUE;
            S_ISSUE: begin
               // a flush landing in the IDLE->ISSUE cycle leaves nothing to issue
               if (!empty) begin
                  write_o   <= 1'b1;
                  led_num_o <= head.led_num;
                  rgb_o     <= head.rgb;
                  gap_cnt   <= GW'(GAP_CYCLES - 1);
                  state     <= S_GAP;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) state <= S_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_cmd_queue.sv
// Randomized and directed bench for ws2812_cmd_queue against a queue-based model.
module tb_ws2812_cmd_queue;

   localparam logic [31:0] BASE   = 32'h30000300;
   localparam int          DEPTH  = 8;
   localparam int          GAP    = 16;
   localparam int          PERIOD = GAP + 2;

   logic        wb_clk_i  = 1'b0;
   logic        wb_rst_n  = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_we_i  = 1'b0;
   logic [3:0]  wbs_sel_i = '0;
   logic [31:0] wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [7:0]  led_num_o;
   logic [23:0] rgb_o;
   logic        write_o;
   logic        busy_o;

   int vectors     = 0;
   int miscompares = 0;
   int cyc_cnt     = 0;

   logic [31:0] pulse_d[$];
   int          pulse_t[$];
   logic [31:0] model_q[$];
   bit          model_ovf = 1'b0;

   ws2812_cmd_queue #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_n  (wb_rst_n),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .led_num_o (led_num_o),
      .rgb_o     (rgb_o),
      .write_o   (write_o),
      .busy_o    (busy_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

   always @(negedge wb_clk_i) begin
      if (write_o) begin
         pulse_d.push_back({led_num_o, rgb_o});
         pulse_t.push_back(cyc_cnt);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status(input int lvl, input bit ovf, input bit paused);
      logic [31:0] w;
      w = 32'(lvl);
      if (lvl == DEPTH) w = w | 32'h100;
      if (lvl == 0)     w = w | 32'h200;
      if (lvl != 0)     w = w | 32'h400;
      if (ovf)          w = w | 32'h1_0000;
      if (paused)       w = w | 32'h2_0000;
      return w;
   endfunction

   task automatic wb_xfer(input logic [31:0] off, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, output logic ackd, output logic [31:0] rd,
                          output int ack_t);
      wbs_adr_i = BASE + off;
      wbs_we_i  = we;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      ackd  = 1'b0;
      rd    = '0;
      ack_t = -1;
      for (int i = 0; i < 4 && !ackd; i++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) begin
            ackd  = 1'b1;
            rd    = wbs_dat_o;
            ack_t = cyc_cnt;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      @(posedge wb_clk_i); #1;
   endtask

   task automatic wb_write(input string tag, input logic [31:0] off, input logic [31:0] dat,
                           input logic [3:0] sel, output int ack_t);
      logic ackd;
      logic [31:0] rd;
      wb_xfer(off, 1'b1, dat, sel, ackd, rd, ack_t);
      check(tag, ackd, 1'b1);
   endtask

   task automatic check_status(input string tag, input bit paused);
      logic ackd;
      logic [31:0] rd;
      int t;
      wb_xfer(32'h4, 1'b0, '0, 4'hF, ackd, rd, t);
      check({tag, "_ack"}, ackd, 1'b1);
      check(tag, rd, exp_status(model_q.size(), model_ovf, paused));
   endtask

   task automatic push_cmd(input logic [31:0] d, input logic [3:0] sel);
      int t;
      wb_write("data_ack", 32'h0, d, sel, t);
      if (sel == 4'hF) begin
         if (model_q.size() == DEPTH) model_ovf = 1'b1;
         else                         model_q.push_back(d);
      end
   endtask

   task automatic wait_pulses(input int n, input int budget);
      while (pulse_d.size() < n && budget > 0) begin
         @(posedge wb_clk_i); #1;
         budget--;
      end
   endtask

   task automatic drain_and_check(input string tag, input logic [31:0] ctrl);
      int t, n;
      pulse_d.delete();
      pulse_t.delete();
      wb_write({tag, "_ctrl"}, 32'h8, ctrl, 4'h1, t);
      wait_pulses(model_q.size(), model_q.size() * PERIOD + 10);
      repeat (PERIOD + 4) @(posedge wb_clk_i);
      #1;
      check({tag, "_count"}, pulse_d.size(), model_q.size());
      n = (pulse_d.size() < model_q.size()) ? pulse_d.size() : model_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_data"}, pulse_d[i], model_q[i]);
         if (i == 0) check({tag, "_lat"}, pulse_t[0] - t, 2);
         else        check({tag, "_space"}, pulse_t[i] - pulse_t[i-1], PERIOD);
      end
      model_q.delete();
   endtask

   task automatic hold_count(input logic [31:0] off, output int n);
      wbs_adr_i = BASE + off;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'hF;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      n = 0;
      repeat (4) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) n++;
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) n++;
   endtask

   initial begin
      int t, n, iters;
      logic [31:0] d;
      logic [3:0]  sel;

      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_n = 1'b1;

      // reset state
      check("rst_write", write_o, 1'b0);
      check("rst_led", led_num_o, 8'h00);
      check("rst_rgb", rgb_o, 24'h0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_ack", wbs_ack_o, 1'b0);
      check_status("rst_status", 1'b0);

      // single command while idle
      pulse_d.delete();
      pulse_t.delete();
      wb_write("single_ack", 32'h0, 32'h05FF8000, 4'hF, t);
      wait_pulses(1, 10);
      check("single_count", pulse_d.size(), 1);
      if (pulse_d.size() > 0) begin
         check("single_data", pulse_d[0], 32'h05FF8000);
         check("single_lat", pulse_t[0] - t, 2);
      end
      while (cyc_cnt < t + 17) begin
         @(posedge wb_clk_i); #1;
      end
      check("single_busy_hi", busy_o, 1'b1);
      @(posedge wb_clk_i); #1;
      check("single_busy_lo", busy_o, 1'b0);

      // burst of 9 while paused, then release
      wb_write("pause_ack", 32'h8, 32'h4, 4'h1, t);
      for (int i = 0; i < 9; i++) push_cmd({8'(i + 1), 24'($urandom)}, 4'hF);
      check_status("burst_status", 1'b1);
      drain_and_check("burst", 32'h0);
      check_status("burst_after", 1'b0);

      // overflow clear, partial-sel write ignored
      wb_write("clr_ovf_ack", 32'h8, 32'h2, 4'h1, t);
      model_ovf = 1'b0;
      check_status("ovf_clear", 1'b0);
      wb_write("pause2_ack", 32'h8, 32'h4, 4'h1, t);
      push_cmd(32'h11223344, 4'hF);
      push_cmd(32'h55667788, 4'h3);
      check_status("partial_sel", 1'b1);

      // flush while paused with 5 queued
      for (int i = 0; i < 4; i++) push_cmd($urandom, 4'hF);
      check_status("five_queued", 1'b1);
      wb_write("flush_ack", 32'h8, 32'h5, 4'h1, t);
      model_q.delete();
      check_status("flush_paused", 1'b1);
      drain_and_check("post_flush", 32'h0);

      // flush during GAP while unpaused
      pulse_d.delete();
      pulse_t.delete();
      for (int i = 0; i < 3; i++) wb_write("gap_push", 32'h0, {8'(i + 8'h20), 24'hABCDEF}, 4'hF, t);
      wait_pulses(1, 20);
      repeat (3) @(posedge wb_clk_i);
      #1;
      wb_write("gap_flush", 32'h8, 32'h1, 4'h1, t);
      repeat (3 * PERIOD) @(posedge wb_clk_i);
      #1;
      check("gap_flush_count", pulse_d.size(), 1);
      if (pulse_d.size() > 0) check("gap_flush_data", pulse_d[0], {8'h20, 24'hABCDEF});
      check_status("gap_flush_status", 1'b0);

      // held request and unmapped address
      hold_count(32'h4, n);
      check("hold_acks", n, 1);
      hold_count(32'hC, n);
      check("unmapped_acks", n, 0);

      // reset during GAP with commands queued
      pulse_d.delete();
      pulse_t.delete();
      for (int i = 0; i < 3; i++) wb_write("rst_push", 32'h0, {8'(i + 8'h40), 24'h123456}, 4'hF, t);
      wait_pulses(1, 20);
      repeat (2) @(posedge wb_clk_i);
      #1 wb_rst_n = 1'b0;
      #1;
      check("arst_write", write_o, 1'b0);
      check("arst_led", led_num_o, 8'h00);
      check("arst_rgb", rgb_o, 24'h0);
      check("arst_busy", busy_o, 1'b0);
      check("arst_dat", wbs_dat_o, 32'h0);
      @(posedge wb_clk_i);
      #1 wb_rst_n = 1'b1;
      pulse_d.delete();
      pulse_t.delete();
      repeat (3 * PERIOD) @(posedge wb_clk_i);
      #1;
      check("arst_no_pulse", pulse_d.size(), 0);
      check_status("arst_status", 1'b0);

      // randomized bursts against the queue model
      iters = 6;
      for (int it = 0; it < iters; it++) begin
         wb_write("rnd_pause", 32'h8, 32'h4, 4'h1, t);
         n = $urandom_range(0, 11);
         for (int i = 0; i < n; i++) begin
            d   = $urandom;
            sel = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            push_cmd(d, sel);
         end
         if ($urandom_range(0, 3) == 0) begin
            wb_write("rnd_flush", 32'h8, 32'h5, 4'h1, t);
            model_q.delete();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) push_cmd($urandom, 4'hF);
         end
         check_status("rnd_status", 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            model_ovf = 1'b0;
            drain_and_check("rnd", 32'h2);
         end else begin
            drain_and_check("rnd", 32'h0);
         end
         check_status("rnd_idle", 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ws2812_cmd_queue.md
Name: ws2812_cmd_queue

Overview:
- Wishbone slave that buffers {led_num, rgb} commands from the CPU in a small FIFO.
- Drains the FIFO toward the ws2812 project with one single-cycle write pulse per command, spaced by a programmable gap, so the CPU can burst LED updates without pacing them.
- Sits between the Wishbone bus and the ws2812 project's led_num/rgb_data/write inputs; the harness routes its ack/data into the bus mux.

Parameters:
- BASE_ADDR, 32'h30000300, byte address of register 0; registers are at +0, +4, +8.
- DEPTH, 8, FIFO entries; power of two, 2..16.
- GAP_CYCLES, 16, idle cycles after each write pulse before the next issue; at least 1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack
- wbs_dat_o  out  32  read data
- led_num_o  out  8  LED index to ws2812
- rgb_o  out  24  colour to ws2812
- write_o  out  1  single-cycle command strobe to ws2812
- busy_o  out  1  FIFO non-empty or drain FSM not IDLE

Behaviour:
- Reset: all outputs, FIFO pointers/level, overflow flag, pause bit, gap counter and FSM state go to 0 / IDLE.
- Reset is asynchronous assert; it may occur mid-drain, and the queue is then lost.
- Bus handshake:
  - valid = cyc & stb & addr matches one of the 3 registers & !ack_o.
  - ack_o is registered: high exactly 1 cycle, 1 cycle after valid.
  - A request held for several cycles produces a single ack.
  - Unmapped addresses are never acked.
- Reg +0 DATA, write:
  - Pushes {wbs_dat_i[31:24], wbs_dat_i[23:0]} only when sel==4'hF.
  - Partial-sel writes are acked and ignored.
  - Read returns 0.
- Reg +4 STATUS, read only:
  - [4:0] level
  - [8] full
  - [9] empty
  - [10] busy
  - [16] overflow (sticky)
  - [17] paused
  - all other bits 0
  - Writes are acked and ignored.
- Reg +8 CTRL, write with sel[0]:
  - bit0 flush: level and pointers go to 0 that cycle.
  - bit1 clear overflow.
  - bit2 pause: level-sensitive, stored.
  - Read returns {29'b0, pause, 2'b0}.
- Push when full:
  - Fullness is judged on pre-pop level.
  - A push coinciding with a pop while full is dropped.
  - The write is still acked and overflow is set.
  - Overflow set and clear in the same cycle: set wins.
- Drain FSM:
  - IDLE: if !empty & !pause, go to ISSUE.
  - ISSUE (1 cycle):
    - Pop the head.
    - Register head into led_num_o/rgb_o; they are valid in the same cycle write_o=1.
    - Load gap counter with GAP_CYCLES-1.
    - Go to GAP.
  - GAP: decrement the counter; at 0 go to IDLE.
  - Latency: push ack to write_o is 2 cycles when idle. Successive write_o pulses are GAP_CYCLES+2 cycles apart.
- led_num_o/rgb_o hold their last value between issues.
- Pause does not abort ISSUE or GAP in progress.
- Flush does not cancel a pulse already issued; the FSM finishes GAP, then sees empty.
- Level never exceeds DEPTH and never underflows. Pop occurs only when non-empty.

Decomposition:
- Package ws2812_cmd_pkg holds:
  - register offsets (0/4/8)
  - STATUS bit positions
  - CTRL bit positions
  - FSM state encoding (IDLE/ISSUE/GAP)
  - the 32-bit command word layout
- One sub-module, ws2812_cmd_fifo:
  - synchronous FIFO of DEPTH x 32 with push, pop, flush, level, full, empty.
  - Same asynchronous active-low reset.
- The top holds the bus decode, registers and drain FSM.

Test Plan:
- Reset, then read STATUS: returns 0x00000200 (empty); write_o, led_num_o and rgb_o are 0.
- Write DATA 0x05FF8000 while idle: ack 1 cycle later. Two cycles after the ack, write_o=1 for one cycle with led_num_o=0x05, rgb_o=0xFF8000. busy_o drops after GAP_CYCLES more cycles.
- Burst 8 DATA writes, then a 9th, with pause=1:
  - The 9th is acked, but STATUS shows level=8, full=1, overflow=1.
  - Clear pause: exactly 8 write_o pulses, 18 cycles apart, in FIFO order.
- Write CTRL bit1, then read STATUS: overflow=0. Write DATA with sel=4'h3: acked, level unchanged.
- With 5 queued and paused, write CTRL flush: level=0 next cycle and no write_o follows. Repeat unpaused, with flush during GAP: the current pulse completes and no further pulses follow.
- Hold stb/cyc 4 cycles on a STATUS read: exactly one ack. Access BASE_ADDR+0xC: no ack. Assert reset during GAP with 3 queued: all outputs are 0 immediately, and no pulses follow after release.
